iopad_bank_ctrl: RTL and testbench
==================================

// Module: iopad_bank_ctrl
// PURPOSE
//   Registered direction/data controller for a bank of WIDTH iopad cells. Sits between fabric
//   logic and the iopad instances: drives each pad's dout/direction, captures each pad's din.
//   A turnaround FSM inserts a dead window on every direction change so pad and fabric never
//   drive together. Direction convention: direction=1 -> input (pad drives din), 0 -> output.
// PARAMETERS
//   WIDTH        4  number of pads in the bank
//   TURN_CYCLES  2  dead cycles per direction change; legal range >=1, 0 is treated as 1
//   SYNC_STAGES  2  input synchronizer depth when IOPAD_SYNC_EN is defined; legal range >=2
// PORTS
//   clk            in   1      single clock, all state on rising edge
//   rst_n          in   1      asynchronous, active-low reset
//   dir_req        in   1      requested bank direction (1=input, 0=output), level-sensitive
//   fab_dout       in   WIDTH  fabric data to drive onto the pads in OUT state
//   fab_din        out  WIDTH  captured pad data toward the fabric
//   fab_din_vld    out  1      fab_din carries synchronized pad data
//   busy           out  1      turnaround in progress
//   pad_din        in   WIDTH  from iopad din
//   pad_dout       out  WIDTH  to iopad dout
//   pad_direction  out  WIDTH  to iopad direction, all bits identical
// BEHAVIOUR
//   Reset (async, immediate): state=IN, pad_direction=all 1, pad_dout=0, fab_din=0,
//     fab_din_vld=0, busy=0, turn counter=0, sync chain=0.
//   All outputs are registered. pad_direction=0 only in OUT. busy=1 only in TURN_OUT and TURN_IN.
//   FSM, transitions on the edge that samples the condition:
//     IN       : dir_req==0 -> TURN_OUT, cnt<=TURN_CYCLES-1
//     TURN_OUT : cnt==0 -> OUT, else cnt--. pad_direction stays 1. pad_dout=0.
//     OUT      : dir_req==1 -> TURN_IN, cnt<=TURN_CYCLES-1. pad_dout<=fab_dout every cycle.
//     TURN_IN  : pad_direction=1 from entry. pad_dout=0. cnt==0 -> IN, else cnt--.
//   dir_req is ignored during TURN_* states and re-evaluated in the destination state.
//     Example: a dir_req change during TURN_OUT gives OUT for exactly 1 cycle, then TURN_IN.
//   pad_direction falls TURN_CYCLES+1 edges after the edge that samples dir_req=0.
//   Output latency: fab_dout to pad_dout is 1 edge, in OUT state only. Outside OUT, pad_dout=0.
//   Input path: pad_din is sampled in every state. fab_din = pad_din delayed by D edges, where
//     D=SYNC_STAGES, or D=1 without the macro.
//   fab_din_vld: 0 outside IN. On entry to IN, a fill counter clears and fab_din_vld rises
//     after D edges in IN. fab_din keeps updating in all states; ignore it while fab_din_vld=0.
//   Counter width: $clog2(TURN_CYCLES+1). No wrap: cnt is never decremented below 0.
//   Reset mid-turn or mid-OUT: pads return to input asynchronously, with no dead cycle needed.
// CONFIGURATION
//   IOPAD_SYNC_EN defined: input path is a SYNC_STAGES-deep flop chain per bit (async pads).
//   IOPAD_SYNC_EN undefined: input path is a single capture flop per bit. SYNC_STAGES is unused.
// STRUCTURE
//   Package iopad_ctrl_pkg:
//     - enum state_t {IN, TURN_OUT, OUT, TURN_IN}
//     - localparams DIR_IN=1'b1, DIR_OUT=1'b0
//   Sub-module iopad_sync_chain (WIDTH, DEPTH): per-bit flop chain with async reset to 0.
//     Instantiated with DEPTH=SYNC_STAGES, or DEPTH=1 without the macro.
//   The top level holds the FSM, turn counter, fill counter and output registers.
// TESTING  (WIDTH=4, TURN_CYCLES=2, SYNC_STAGES=2 unless stated)
//   1 Reset: deassert rst_n -> all outputs at reset values.
//     Pull rst_n low while in OUT -> pad_direction=4'hF, pad_dout=0 before the next edge.
//   2 Turn out: dir_req 1->0 sampled at edge E -> busy=1 after E+1..E+2.
//     pad_direction=4'h0 and busy=0 after E+3.
//   3 Data out: in OUT, fab_dout=4'hA at edge N -> pad_dout=4'hA after N.
//     dir_req=1 -> pad_dout=0 and pad_direction=4'hF after the next edge.
//   4 Data in: in IN, pad_din=4'h5 at edge N -> fab_din=4'h5 after N+1 with IOPAD_SYNC_EN.
//     Without the macro, fab_din=4'h5 after N.
//   5 Glitch request: pulse dir_req 1->0->1 with the 0 one cycle wide ->
//     full TURN_OUT, OUT for exactly 1 cycle, TURN_IN, IN. No cycle has both drivers active.
//   6 Valid refill: after TURN_IN completes, fab_din_vld=0 for 2 cycles in IN, then 1.

Source files
------------

// File: rtl/iopad_ctrl_pkg.sv
// iopad_ctrl_pkg: shared types and constants for the iopad bank controller.
//   state_t  - turnaround FSM states
//   DIR_IN   - pad direction encoding for input (pad drives din)
//   DIR_OUT  - pad direction encoding for output (pad driven from dout)
package iopad_ctrl_pkg;

    typedef enum logic [1:0] {
        IN       = 2'd0,
        TURN_OUT = 2'd1,
        OUT      = 2'd2,
        TURN_IN  = 2'd3
    } state_t;

    localparam logic DIR_IN  = 1'b1;
    localparam logic DIR_OUT = 1'b0;

endpackage

// File: rtl/iopad_sync_chain.sv
// iopad_sync_chain: per-bit flop chain, DEPTH stages, async reset to 0.
// Ports:
//   clk    in   1      clock
//   rst_n  in   1      asynchronous active-low reset
//   d      in   WIDTH  data in
//   q      out  WIDTH  data delayed by DEPTH edges
module iopad_sync_chain #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/iopad_bank_ctrl.sv
// iopad_bank_ctrl: registered direction/data controller for a bank of WIDTH iopad cells.
// A turnaround FSM (IN -> TURN_OUT -> OUT -> TURN_IN -> IN) inserts TURN_CYCLES dead cycles
// on every direction change so pad and fabric never drive together.
// Configuration macro: IOPAD_SYNC_EN -- when defined the input path is a SYNC_STAGES-deep
// synchronizer; otherwise a single capture flop (SYNC_STAGES unused).
// Ports:
//   clk            in   1      clock, rising edge
//   rst_n          in   1      asynchronous active-low reset
//   dir_req        in   1      requested direction (1=input, 0=output)
//   fab_dout       in   WIDTH  fabric data driven onto pads in OUT
//   fab_din        out  WIDTH  captured pad data toward fabric
//   fab_din_vld    out  1      fab_din holds data sampled entirely in IN
//   busy           out  1      turnaround in progress
//   pad_din        in   WIDTH  from iopad din
//   pad_dout       out  WIDTH  to iopad dout
//   pad_direction  out  WIDTH  to iopad direction (all bits identical)
module iopad_bank_ctrl
    import iopad_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dir_req,
    input  logic [WIDTH-1:0] fab_dout,
    output logic [WIDTH-1:0] fab_din,
    output logic             fab_din_vld,
    output logic             busy,
    input  logic [WIDTH-1:0] pad_din,
    output logic [WIDTH-1:0] pad_dout,
    output logic [WIDTH-1:0] pad_direction
);

    // A turnaround of zero cycles is unsafe; clamp to one.
    localparam int unsigned TURN_EFF = (TURN_CYCLES < 1) ? 1 : TURN_CYCLES;
    localparam int unsigned CNT_W    = $clog2(TURN_EFF + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TURN_EFF - 1);

`ifdef IOPAD_SYNC_EN
    localparam int unsigned DIN_DEPTH = SYNC_STAGES;
`else
    localparam int unsigned DIN_DEPTH = 1;
`endif

    localparam int unsigned FILL_W = $clog2(DIN_DEPTH + 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(DIN_DEPTH);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DIN_DEPTH - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [FILL_W-1:0] fill;

    iopad_sync_chain #(
        .WIDTH (WIDTH),
        .DEPTH (DIN_DEPTH)
    ) u_din_chain (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pad_din),
        .q     (fab_din)
    );

    // Pad drive is released on the same edge that leaves OUT, but only enabled one edge
    // after OUT is entered, so the direction output lags state on the way in only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IN;
            cnt           <= '0;
            fill          <= '0;
            fab_din_vld   <= 1'b0;
            busy          <= 1'b0;
            pad_dout      <= '0;
            pad_direction <= {WIDTH{DIR_IN}};
        end else begin
            busy          <= (state == TURN_OUT) || (state == TURN_IN);
            pad_direction <= {WIDTH{DIR_IN}};
            pad_dout      <= '0;
            fab_din_vld   <= 1'b0;
            fill          <= '0;

            unique case (state)
                IN: begin
                    if (!dir_req) begin
                        state <= TURN_OUT;
                        cnt   <= CNT_LOAD;
                    end else begin
                        // Saturating fill count: valid once the chain holds only IN samples.
                        fill        <= (fill == FILL_MAX) ? fill : fill + 1'b1;
                        fab_din_vld <= (fill >= FILL_LAST);
                    end
                end
                TURN_OUT: begin
                    if (cnt == '0) begin
                        state <= OUT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                OUT: begin
                    if (dir_req) begin
                        state <= TURN_IN;
                        cnt   <= CNT_LOAD;
                    end else begin
                        pad_direction <= {WIDTH{DIR_OUT}};
                        pad_dout      <= fab_dout;
                    end
                end
                TURN_IN: begin
                    if (cnt == '0) begin
                        state <= IN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IN;
            endcase
        end
    end

endmodule

// File: tb/tb_iopad_bank_ctrl.sv
// Directed table-driven bench for iopad_bank_ctrl (TURN_CYCLES=2) plus a second
// instance with TURN_CYCLES=0 (treated as 1) sharing the same stimulus.
module tb_iopad_bank_ctrl;

`ifdef IOPAD_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dir_req;
    logic [3:0] fab_dout;
    logic [3:0] pad_din;

    logic [3:0] fab_din, pad_dout, pad_direction;
    logic       fab_din_vld, busy;
    logic [3:0] fab_din0, pad_dout0, pad_direction0;
    logic       fab_din_vld0, busy0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iopad_bank_ctrl #(
        .WIDTH       (4),
        .TURN_CYCLES (2),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dir_req       (dir_req),
        .fab_dout      (fab_dout),
        .fab_din       (fab_din),
        .fab_din_vld   (fab_din_vld),
        .busy          (busy),
        .pad_din       (pad_din),
        .pad_dout      (pad_dout),
        .pad_direction (pad_direction)
    );

    iopad_bank_ctrl #(
        .WIDTH       (4),
        .TURN_CYCLES (0),
        .SYNC_STAGES (2)
    ) u_dut0 (
        .clk           (clk),
        .rst_n         (rst_n),
        .dir_req       (dir_req),
        .fab_dout      (fab_dout),
        .fab_din       (fab_din0),
        .fab_din_vld   (fab_din_vld0),
        .busy          (busy0),
        .pad_din       (pad_din),
        .pad_dout      (pad_dout0),
        .pad_direction (pad_direction0)
    );

    typedef struct {
        logic       dir_req;
        logic [3:0] fab_dout;
        logic [3:0] pad_din;
        logic [3:0] e_dir;
        logic [3:0] e_dout;
        logic       e_busy;
        logic       e_vld1;
        logic       e_vld2;
        logic [3:0] e0_dir;
        logic [3:0] e0_dout;
        logic       e0_busy;
    } vec_t;

    vec_t       tbl [20];
    logic [3:0] hist [$];

    task automatic chk(input string name, input int row, input logic [3:0] act,
                       input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d actual=%h required=%h", name, row, act, exp);
        end
    endtask

    initial begin
        logic [3:0] e_din;
        logic       e_vld;

        //            req fdo  pin  dir  dout bsy v1 v2 | dir0 dout0 bsy0
        tbl[0]  = '{1'b1, 4'h3, 4'h5, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 1'b0};
        tbl[1]  = '{1'b1, 4'h3, 4'h6, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1, 4'hF, 4'h0, 1'b0};
        tbl[2]  = '{1'b0, 4'h7, 4'h9, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 1'b0};
        tbl[3]  = '{1'b0, 4'h7, 4'hA, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 1'b1};
        tbl[4]  = '{1'b0, 4'h8, 4'hB, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h8, 1'b0};
        tbl[5]  = '{1'b0, 4'hA, 4'hC, 4'h0, 4'hA, 1'b0, 1'b0, 1'b0, 4'h0, 4'hA, 1'b0};
        tbl[6]  = '{1'b0, 4'h5, 4'hD, 4'h0, 4'h5, 1'b0, 1'b0, 1'b0, 4'h0, 4'h5, 1'b0};
        tbl[7]  = '{1'b1, 4'h6, 4'hE, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 1'b0};
        tbl[8]  = '{1'b1, 4'h6, 4'h1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 1'b1};
        tbl[9]  = '{1'b1, 4'h6, 4'h2, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 1'b0};
        tbl[10] = '{1'b1, 4'h6, 4'h3, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 1'b0};
        tbl[11] = '{1'b1, 4'h6, 4'h4, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1, 4'hF, 4'h0, 1'b0};
        // One-cycle-wide dir_req=0 pulse: full turn-out, OUT for one cycle, turn-in.
        tbl[12] = '{1'b0, 4'hF, 4'h7, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 1'b0};
        tbl[13] = '{1'b1, 4'hF, 4'h8, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 1'b1};
        tbl[14] = '{1'b1, 4'hF, 4'h9, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 1'b0};
        tbl[15] = '{1'b1, 4'hF, 4'hA, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 4'hF, 4'h0, 1'b1};
        tbl[16] = '{1'b1, 4'hF, 4'hB, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 1'b0};
        tbl[17] = '{1'b1, 4'hF, 4'hC, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 4'hF, 4'h0, 1'b0};
        tbl[18] = '{1'b1, 4'hF, 4'hD, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 1'b0};
        tbl[19] = '{1'b1, 4'hF, 4'hE, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1, 4'hF, 4'h0, 1'b0};

        rst_n    = 1'b0;
        dir_req  = 1'b1;
        fab_dout = 4'h0;
        pad_din  = 4'h0;
        #12;
        chk("reset_dir",  -1, pad_direction, 4'hF);
        chk("reset_dout", -1, pad_dout, 4'h0);
        chk("reset_busy", -1, {3'b0, busy}, 4'h0);
        chk("reset_vld",  -1, {3'b0, fab_din_vld}, 4'h0);
        chk("reset_din",  -1, fab_din, 4'h0);
        #10 rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            dir_req  = tbl[i].dir_req;
            fab_dout = tbl[i].fab_dout;
            pad_din  = tbl[i].pad_din;
            hist.push_back(tbl[i].pad_din);
            @(posedge clk);
            #1;
            e_din = (hist.size() >= D) ? hist[hist.size() - D] : 4'h0;
            e_vld = (D == 1) ? tbl[i].e_vld1 : tbl[i].e_vld2;
            chk("pad_direction",  i, pad_direction, tbl[i].e_dir);
            chk("pad_dout",       i, pad_dout, tbl[i].e_dout);
            chk("busy",           i, {3'b0, busy}, {3'b0, tbl[i].e_busy});
            chk("fab_din_vld",    i, {3'b0, fab_din_vld}, {3'b0, e_vld});
            chk("fab_din",        i, fab_din, e_din);
            chk("t0_pad_direction", i, pad_direction0, tbl[i].e0_dir);
            chk("t0_pad_dout",    i, pad_dout0, tbl[i].e0_dout);
            chk("t0_busy",        i, {3'b0, busy0}, {3'b0, tbl[i].e0_busy});
            chk("t0_fab_din",     i, fab_din0, e_din);
        end

        // Reset asserted while both instances drive the pads.
        dir_req  = 1'b0;
        fab_dout = 4'h9;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_dir",   20, pad_direction, 4'h0);
        chk("pre_rst_dout",  20, pad_dout, 4'h9);
        chk("pre_rst_dir0",  20, pad_direction0, 4'h0);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_dir",   21, pad_direction, 4'hF);
        chk("async_rst_dout",  21, pad_dout, 4'h0);
        chk("async_rst_busy",  21, {3'b0, busy}, 4'h0);
        chk("async_rst_din",   21, fab_din, 4'h0);
        chk("async_rst_dir0",  21, pad_direction0, 4'hF);
        chk("async_rst_dout0", 21, pad_dout0, 4'h0);
        @(posedge clk);
        #1;
        dir_req = 1'b1;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_dir",  22, pad_direction, 4'hF);
        chk("post_rst_busy", 22, {3'b0, busy}, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
